// File: rtl/psw_pkg.sv
// Shared types and default timing constants for the push-switch filter.
package psw_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   localparam int unsigned DB_CYCLES_DEF     = 500000;
   localparam int unsigned LONG_CYCLES_DEF   = 50000000;
   localparam int unsigned REPEAT_CYCLES_DEF = 10000000;
   localparam bit          ACT_LOW_DEF       = 1'b1;

endpackage

// File: rtl/psw_sync.sv
// Two-flop synchronizer for an asynchronous level; reset loads RST_LVL into both stages.
module psw_sync #(
   parameter logic RST_LVL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_LVL;
         q    <= RST_LVL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/psw_filter.sv
// Push-switch debouncer with press/release/long-press pulses.
// Define PSW_REPEAT_EN to add auto-repeat PSW_PUSH pulses after a long press.
module psw_filter
   import psw_pkg::*;
#(
   parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
   parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
   parameter bit          ACT_LOW       = ACT_LOW_DEF
) (
   input  logic CK,
   input  logic RB,
   input  logic PSW,
   output logic PSW_LVL,
   output logic PSW_PUSH,
   output logic PSW_REL,
   output logic PSW_LONG
);

   localparam int unsigned DB_W   = $clog2(DB_CYCLES) + 1;
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;

   state_t              state, state_n;
   logic [DB_W-1:0]     db_cnt, db_cnt_n;
   logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
   logic                lvl_n, push_n, rel_n, long_n;
   logic                sync_q, pressed, hold_sat;

`ifdef PSW_REPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_CYCLES) + 1;
   logic [REP_W-1:0]    rep_cnt, rep_cnt_n;
`endif

   psw_sync #(
      .RST_LVL (ACT_LOW ? 1'b1 : 1'b0)
   ) u_sync (
      .clk (CK),
      .rst (RB),
      .d   (PSW),
      .q   (sync_q)
   );

   assign pressed  = ACT_LOW ? ~sync_q : sync_q;
   // Hold counter parks at LONG_CYCLES-1 so PSW_LONG cannot repeat on very long holds
   assign hold_sat = (hold_cnt == HOLD_W'(LONG_CYCLES - 1));

   // Next-state, counters and output pulses
   always_comb begin
      state_n    = state;
      db_cnt_n   = db_cnt;
      hold_cnt_n = hold_cnt;
      lvl_n      = PSW_LVL;
      push_n     = 1'b0;
      rel_n      = 1'b0;
      long_n     = 1'b0;
`ifdef PSW_REPEAT_EN
      rep_cnt_n  = rep_cnt;
`endif

      if ((state == HELD || state == REL_DB) && !hold_sat) begin
         hold_cnt_n = hold_cnt + HOLD_W'(1);
         long_n     = (hold_cnt == HOLD_W'(LONG_CYCLES - 2));
      end

      case (state)
         IDLE: begin
            if (pressed) begin
               state_n  = PRESS_DB;
               db_cnt_n = DB_W'(1);
            end
         end
         PRESS_DB: begin
            if (!pressed) begin
               state_n  = IDLE;
               db_cnt_n = '0;
            end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
               state_n    = HELD;
               db_cnt_n   = '0;
               hold_cnt_n = '0;
               lvl_n      = 1'b1;
               push_n     = 1'b1;
            end else begin
               db_cnt_n = db_cnt + DB_W'(1);
            end
         end
         HELD: begin
            if (!pressed) begin
               state_n  = REL_DB;
               db_cnt_n = DB_W'(1);
            end
         end
         REL_DB: begin
            if (pressed) begin
               state_n  = HELD;
               db_cnt_n = '0;
            end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
               state_n  = IDLE;
               db_cnt_n = '0;
               lvl_n    = 1'b0;
               rel_n    = 1'b1;
            end else begin
               db_cnt_n = db_cnt + DB_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      // A long press that matures on the release edge is dropped to keep pulses exclusive
      if (rel_n) long_n = 1'b0;

`ifdef PSW_REPEAT_EN
      if (state_n == IDLE) begin
         rep_cnt_n = '0;
      end else if (state == HELD && pressed) begin
         if (long_n) begin
            push_n    = 1'b1;
            rep_cnt_n = '0;
         end else if (hold_sat) begin
            if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
               push_n    = 1'b1;
               rep_cnt_n = '0;
            end else begin
               rep_cnt_n = rep_cnt + REP_W'(1);
            end
         end
      end
`endif
   end

   always_ff @(posedge CK) begin
      if (RB) begin
         state    <= IDLE;
         db_cnt   <= '0;
         hold_cnt <= '0;
         PSW_LVL  <= 1'b0;
         PSW_PUSH <= 1'b0;
         PSW_REL  <= 1'b0;
         PSW_LONG <= 1'b0;
`ifdef PSW_REPEAT_EN
         rep_cnt  <= '0;
`endif
      end else begin
         state    <= state_n;
         db_cnt   <= db_cnt_n;
         hold_cnt <= hold_cnt_n;
         PSW_LVL  <= lvl_n;
         PSW_PUSH <= push_n;
         PSW_REL  <= rel_n;
         PSW_LONG <= long_n;
`ifdef PSW_REPEAT_EN
         rep_cnt  <= rep_cnt_n;
`endif
      end
   end

endmodule
